// File: rtl/pcihellocore_pio_pkg.sv
// Shared register map constants for the blinking output PIO.
package pcihellocore_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_BLINK  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_OUTTGL = 3'd6;

  localparam int unsigned STAT_PHASE = 0;

endpackage

// File: rtl/pcihellocore_blink_timer.sv
// Free-running half-period timer; phase flips every period+1 cycles.
module pcihellocore_blink_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt_r;
  logic                phase_r;

  // Counter and phase; a restart overrides a wrap in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= {PERIOD_W{1'b0}};
      phase_r <= 1'b0;
    end else if (restart) begin
      cnt_r   <= {PERIOD_W{1'b0}};
      phase_r <= 1'b0;
    end else if (cnt_r == period) begin
      cnt_r   <= {PERIOD_W{1'b0}};
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + PERIOD_W'(1'b1);
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/pcihellocore_pio_out_blink.sv
// Avalon-MM output PIO with atomic set/clear/toggle and per-bit hardware blink.
module pcihellocore_pio_out_blink
  import pcihellocore_pio_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VALUE  = 32'd15,
  parameter int unsigned PERIOD_W     = 24,
  parameter logic [31:0] RESET_PERIOD = 32'd12499999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    data_r;
  logic [WIDTH-1:0]    blink_en_r;
  logic [PERIOD_W-1:0] period_r;
  logic                phase_s;
  logic                wr_s;
  logic                period_wr_s;
  logic [WIDTH-1:0]    wd_data_s;

  assign wr_s        = chipselect && !write_n;
  assign period_wr_s = wr_s && (address == ADDR_PERIOD);
  assign wd_data_s   = writedata[WIDTH-1:0];

  // Register file with atomic read-modify-write ports on DATA.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r     <= RESET_VALUE[WIDTH-1:0];
      blink_en_r <= {WIDTH{1'b0}};
      period_r   <= RESET_PERIOD[PERIOD_W-1:0];
    end else if (wr_s) begin
      case (address)
        ADDR_DATA:   data_r     <= wd_data_s;
        ADDR_BLINK:  blink_en_r <= wd_data_s;
        ADDR_PERIOD: period_r   <= writedata[PERIOD_W-1:0];
        ADDR_OUTSET: data_r     <= data_r | wd_data_s;
        ADDR_OUTCLR: data_r     <= data_r & ~wd_data_s;
        ADDR_OUTTGL: data_r     <= data_r ^ wd_data_s;
        default:     data_r     <= data_r;
      endcase
    end
  end

  pcihellocore_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_r),
    .restart (period_wr_s),
    .phase   (phase_s)
  );

  // Zero-latency read mux; write-only and reserved addresses read 0.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_r);
      ADDR_BLINK:  readdata = 32'(blink_en_r);
      ADDR_PERIOD: readdata = 32'(period_r);
      ADDR_STATUS: readdata[STAT_PHASE] = phase_s;
      default:     readdata = 32'd0;
    endcase
  end

  assign out_port = data_r ^ (blink_en_r & {WIDTH{phase_s}});

endmodule
